// File: rtl/doorlock_pkg.sv
// Shared key codes, display modes and FSM state type for the door-lock keypad path.
package doorlock_pkg;

  localparam logic [3:0] KEY_BKSP     = 4'd10;
  localparam logic [3:0] KEY_ENTER    = 4'd11;
  localparam logic [3:0] KEY_CLEAR    = 4'd12;

  localparam logic [1:0] MODE_IDLE    = 2'b00;
  localparam logic [1:0] MODE_ENTRY   = 2'b01;
  localparam logic [1:0] MODE_HOLD    = 2'b10;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } state_e;

  function automatic logic [1:0] mode_of(input state_e s);
    logic [1:0] m;
    m = MODE_IDLE;
    case (s)
      ENTRY:   m = MODE_ENTRY;
      HOLD:    m = MODE_HOLD;
      default: m = MODE_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Loadable up-counter with synchronous clear and terminal-count compare.
module entry_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load_en,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load_en) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term = (cnt_q == term);

endmodule

// File: rtl/keypad_digit_entry.sv
// Collects decoded keypad digits into a 4-digit BCD buffer, drives the display
// word and hands completed codes to the lock compare logic.
module keypad_digit_entry
  import doorlock_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned HOLD_CYCLES    = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] sevenseg_out,
  output logic        code_valid,
  output logic [15:0] code_out,
  output logic        entry_err,
  output logic [2:0]  digit_count
);

  localparam int unsigned TMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  state_e      state_q, state_d;
  logic [15:0] buf_q, buf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] code_q, code_d;
  logic        cv_q, cv_d;
  logic        err_q, err_d;
  logic [17:0] seg_q, seg_d;

  logic          is_digit;
  logic          key_hit;
  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_at_term;
  logic [TW-1:0] tmr_term;

  assign is_digit = (key_code <= 4'd9);
  assign tmr_term = (state_q == HOLD) ? TW'(HOLD_CYCLES - 1) : TW'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    cv_d    = 1'b0;
    err_d   = 1'b0;
    key_hit = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid && is_digit) begin
          state_d = ENTRY;
          buf_d   = {{3{BLANK_NIBBLE}}, key_code};
          cnt_d   = 3'd1;
        end
      end

      ENTRY: begin
        // A key in the terminal cycle wins over the timeout; codes 13-15 are invisible.
        if (key_valid && (key_code <= KEY_CLEAR)) begin
          key_hit = 1'b1;
          if (is_digit) begin
            if (cnt_q < 3'd4) begin
              buf_d = {buf_q[11:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == KEY_BKSP) begin
            buf_d = {BLANK_NIBBLE, buf_q[15:4]};
            cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          end else if (key_code == KEY_CLEAR) begin
            state_d = IDLE;
            buf_d   = '1;
            cnt_d   = 3'd0;
          end else if (cnt_q == 3'd4) begin
            state_d = HOLD;
            code_d  = buf_q;
            cv_d    = 1'b1;
            cnt_d   = 3'd0;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            buf_d   = '1;
            cnt_d   = 3'd0;
          end
        end else if (tmr_at_term) begin
          state_d = IDLE;
          buf_d   = '1;
          cnt_d   = 3'd0;
        end
      end

      HOLD: begin
        if (tmr_at_term) begin
          state_d = IDLE;
          buf_d   = '1;
        end
      end

      default: begin
        state_d = IDLE;
        buf_d   = '1;
        cnt_d   = 3'd0;
      end
    endcase

    tmr_clr = (state_d != state_q) || key_hit || (state_q == IDLE);
    tmr_en  = (state_q != IDLE);
    seg_d   = {mode_of(state_d), buf_d};
  end

  entry_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (tmr_clr),
    .load_en  (1'b0),
    .load_val ('0),
    .en       (tmr_en),
    .term     (tmr_term),
    .at_term  (tmr_at_term)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '1;
      cnt_q   <= '0;
      code_q  <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
      seg_q   <= {MODE_IDLE, 16'hFFFF};
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      cv_q    <= cv_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
    end
  end

  assign sevenseg_out = seg_q;
  assign code_valid   = cv_q;
  assign code_out     = code_q;
  assign entry_err    = err_q;
  assign digit_count  = cnt_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Self-checking bench for keypad_digit_entry: vector table plus hand-built timeout/reset sequences.
module tb_keypad_digit_entry;

  logic        clk;
  logic        reset_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] sevenseg_out;
  logic        code_valid;
  logic [15:0] code_out;
  logic        entry_err;
  logic [2:0]  digit_count;

  keypad_digit_entry #(
    .TIMEOUT_CYCLES (20),
    .HOLD_CYCLES    (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .sevenseg_out (sevenseg_out),
    .code_valid   (code_valid),
    .code_out     (code_out),
    .entry_err    (entry_err),
    .digit_count  (digit_count)
  );

  typedef struct {
    bit          kv;
    logic [3:0]  kc;
    logic [17:0] seg;
    logic [2:0]  cnt;
    bit          cv;
    bit          err;
    logic [15:0] code;
    string       tag;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(bit kv, logic [3:0] kc, logic [17:0] seg, logic [2:0] cnt,
                              bit cv, bit err, logic [15:0] code, string tag);
    vec_t v;
    v.kv = kv; v.kc = kc; v.seg = seg; v.cnt = cnt;
    v.cv = cv; v.err = err; v.code = code; v.tag = tag;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [17:0] seg, input logic [2:0] cnt,
                         input bit cv, input bit err, input logic [15:0] code);
    total_cnt++;
    if (sevenseg_out === seg && digit_count === cnt && code_valid === cv &&
        entry_err === err && code_out === code) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got seg=%05h cnt=%0d cv=%0b err=%0b code=%04h required seg=%05h cnt=%0d cv=%0b err=%0b code=%04h",
               tag, sevenseg_out, digit_count, code_valid, entry_err, code_out,
               seg, cnt, cv, err, code);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      total_cnt++;
      $display("FAIL scoreboard: got empty queue required pending expectation");
    end else begin
      e = exp_q.pop_front();
      compare(e.tag, e.seg, e.cnt, e.cv, e.err, e.code);
    end
  endtask

  // Drive one cycle of stimulus, record its expectation, sample 1 time unit after the edge.
  task automatic step(input vec_t v);
    key_valid = v.kv;
    key_code  = v.kc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    check_out();
  endtask

  task automatic idle_n(input int n, input logic [17:0] seg, input logic [2:0] cnt,
                        input logic [15:0] code, input string tag);
    for (int i = 0; i < n; i++) step(mk(0, 4'd0, seg, cnt, 0, 0, code, tag));
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    compare(tag, 18'h0FFFF, 3'd0, 0, 0, 16'h0000);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    #1 reset_n = 1'b0;
    #1 compare("reset_values", 18'h0FFFF, 3'd0, 0, 0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Submit 1234, hold with ignored keys, return to idle.
    tbl.push_back(mk(1, 4'd1,  18'h1FFF1, 3'd1, 0, 0, 16'h0000, "entry_d1"));
    tbl.push_back(mk(1, 4'd2,  18'h1FF12, 3'd2, 0, 0, 16'h0000, "entry_d2"));
    tbl.push_back(mk(1, 4'd3,  18'h1F123, 3'd3, 0, 0, 16'h0000, "entry_d3"));
    tbl.push_back(mk(1, 4'd4,  18'h11234, 3'd4, 0, 0, 16'h0000, "entry_d4"));
    tbl.push_back(mk(1, 4'd11, 18'h21234, 3'd0, 1, 0, 16'h1234, "submit"));
    tbl.push_back(mk(0, 4'd0,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_1"));
    tbl.push_back(mk(0, 4'd0,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_2"));
    tbl.push_back(mk(1, 4'd5,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_key_ignored"));
    tbl.push_back(mk(0, 4'd0,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_4"));
    tbl.push_back(mk(1, 4'd11, 18'h21234, 3'd0, 0, 0, 16'h1234, "hold_enter_ignored"));
    tbl.push_back(mk(0, 4'd0,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_6"));
    tbl.push_back(mk(0, 4'd0,  18'h21234, 3'd0, 0, 0, 16'h1234, "hold_7"));
    tbl.push_back(mk(0, 4'd0,  18'h0FFFF, 3'd0, 0, 0, 16'h1234, "hold_expire"));
    // Backspace, overflow digit ignored, clear.
    tbl.push_back(mk(1, 4'd5,  18'h1FFF5, 3'd1, 0, 0, 16'h1234, "d5"));
    tbl.push_back(mk(1, 4'd6,  18'h1FF56, 3'd2, 0, 0, 16'h1234, "d6"));
    tbl.push_back(mk(1, 4'd10, 18'h1FFF5, 3'd1, 0, 0, 16'h1234, "backspace"));
    tbl.push_back(mk(1, 4'd7,  18'h1FF57, 3'd2, 0, 0, 16'h1234, "d7"));
    tbl.push_back(mk(1, 4'd8,  18'h1F578, 3'd3, 0, 0, 16'h1234, "d8"));
    tbl.push_back(mk(1, 4'd9,  18'h15789, 3'd4, 0, 0, 16'h1234, "d9"));
    tbl.push_back(mk(1, 4'd0,  18'h15789, 3'd4, 0, 0, 16'h1234, "fifth_digit_ignored"));
    tbl.push_back(mk(1, 4'd12, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "clear_full"));
    // Short enter, idle ignores non-digits.
    tbl.push_back(mk(1, 4'd3,  18'h1FFF3, 3'd1, 0, 0, 16'h1234, "short_d1"));
    tbl.push_back(mk(1, 4'd3,  18'h1FF33, 3'd2, 0, 0, 16'h1234, "short_d2"));
    tbl.push_back(mk(1, 4'd11, 18'h0FFFF, 3'd0, 0, 1, 16'h1234, "short_enter_err"));
    tbl.push_back(mk(0, 4'd0,  18'h0FFFF, 3'd0, 0, 0, 16'h1234, "err_one_cycle"));
    tbl.push_back(mk(1, 4'd13, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "idle_13"));
    tbl.push_back(mk(1, 4'd11, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "idle_enter"));
    tbl.push_back(mk(1, 4'd10, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "idle_bksp"));
    tbl.push_back(mk(1, 4'd1,  18'h1FFF1, 3'd1, 0, 0, 16'h1234, "clr_d1"));
    tbl.push_back(mk(1, 4'd2,  18'h1FF12, 3'd2, 0, 0, 16'h1234, "clr_d2"));
    tbl.push_back(mk(1, 4'd12, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "clear"));

    foreach (tbl[i]) step(tbl[i]);

    // Inactivity timeout: 19 quiet cycles stay in entry, the 20th discards.
    step(mk(1, 4'd9, 18'h1FFF9, 3'd1, 0, 0, 16'h1234, "to_d9"));
    idle_n(19, 18'h1FFF9, 3'd1, 16'h1234, "to_wait");
    step(mk(0, 4'd0, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "to_expire"));

    // Key on the terminal cycle keeps entry alive and restarts the timer.
    step(mk(1, 4'd9, 18'h1FFF9, 3'd1, 0, 0, 16'h1234, "tk_d9"));
    idle_n(19, 18'h1FFF9, 3'd1, 16'h1234, "tk_wait");
    step(mk(1, 4'd8, 18'h1FF98, 3'd2, 0, 0, 16'h1234, "tk_last_cycle_key"));
    // Ignored code 13 does not restart the timer.
    idle_n(3, 18'h1FF98, 3'd2, 16'h1234, "tk_wait2");
    step(mk(1, 4'd13, 18'h1FF98, 3'd2, 0, 0, 16'h1234, "tk_code13"));
    idle_n(15, 18'h1FF98, 3'd2, 16'h1234, "tk_wait3");
    step(mk(0, 4'd0, 18'h0FFFF, 3'd0, 0, 0, 16'h1234, "tk_expire"));

    // Asynchronous reset mid-entry.
    step(mk(1, 4'd4, 18'h1FFF4, 3'd1, 0, 0, 16'h1234, "rst_d1"));
    step(mk(1, 4'd4, 18'h1FF44, 3'd2, 0, 0, 16'h1234, "rst_d2"));
    pulse_reset("reset_mid_entry");
    step(mk(1, 4'd7, 18'h1FFF7, 3'd1, 0, 0, 16'h0000, "post_reset_d7"));
    step(mk(1, 4'd12, 18'h0FFFF, 3'd0, 0, 0, 16'h0000, "post_reset_clear"));

    // Asynchronous reset mid-hold.
    step(mk(1, 4'd4,  18'h1FFF4, 3'd1, 0, 0, 16'h0000, "h_d4"));
    step(mk(1, 4'd3,  18'h1FF43, 3'd2, 0, 0, 16'h0000, "h_d3"));
    step(mk(1, 4'd2,  18'h1F432, 3'd3, 0, 0, 16'h0000, "h_d2"));
    step(mk(1, 4'd1,  18'h14321, 3'd4, 0, 0, 16'h0000, "h_d1"));
    step(mk(1, 4'd11, 18'h24321, 3'd0, 1, 0, 16'h4321, "h_submit"));
    step(mk(0, 4'd0,  18'h24321, 3'd0, 0, 0, 16'h4321, "h_hold"));
    pulse_reset("reset_mid_hold");
    idle_n(3, 18'h0FFFF, 3'd0, 16'h0000, "post_hold_reset");

    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
